// File: rtl/fb_id_ex.sv
// Firebird RV32I ID/EX pipeline register.
// Load-use bubble insertion, flush and EX hold.
module fb_id_ex #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_alu_res_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             id_mem_to_reg,
  input  logic             id_reg_write,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_5,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_alu_res_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_mem_to_reg,
  output logic             ex_reg_write,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic hazard;
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);

  assign hazard = ex_valid & ex_mem_read
                & (ex_rd != 5'd0) & id_valid
                & (rs1_hit | rs2_hit);

  assign stall_id = (hazard | ex_hold) & ~flush;

  // Bubbles only clear valid and control; data fields are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_funct7_5    <= 1'b0;
      ex_alu_op      <= 2'b00;
      ex_alu_src     <= 1'b0;
      ex_alu_res_src <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_reg_write   <= 1'b0;
      bubble_cnt     <= '0;
    end else if (flush || (!ex_hold && hazard)) begin
      ex_valid       <= 1'b0;
      ex_alu_op      <= 2'b00;
      ex_alu_src     <= 1'b0;
      ex_alu_res_src <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_reg_write   <= 1'b0;
      if (!flush && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (!ex_hold) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_rs1_data    <= id_rs1_data;
      ex_rs2_data    <= id_rs2_data;
      ex_imm         <= id_imm;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_funct3      <= id_funct3;
      ex_funct7_5    <= id_funct7_5;
      ex_alu_op      <= id_valid ? id_alu_op : 2'b00;
      ex_alu_src     <= id_valid & id_alu_src;
      ex_alu_res_src <= id_valid & id_alu_res_src;
      ex_mem_read    <= id_valid & id_mem_read;
      ex_mem_write   <= id_valid & id_mem_write;
      ex_branch      <= id_valid & id_branch;
      ex_mem_to_reg  <= id_valid & id_mem_to_reg;
      ex_reg_write   <= id_valid & id_reg_write;
    end
  end

endmodule

// File: tb/tb_fb_id_ex.sv
// Testbench for fb_id_ex: directed steps plus random traffic
// checked against a behavioural model of the EX register.
module tb_fb_id_ex;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, flush, ex_hold;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic id_funct7_5, id_uses_rs1, id_uses_rs2;
  logic [1:0] id_alu_op;
  logic id_alu_src, id_alu_res_src, id_mem_read, id_mem_write;
  logic id_branch, id_mem_to_reg, id_reg_write;

  logic ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic ex_funct7_5;
  logic [1:0] ex_alu_op;
  logic ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write;
  logic ex_branch, ex_mem_to_reg, ex_reg_write;
  logic stall_id;
  logic [CNT_W-1:0] bubble_cnt;

  fb_id_ex #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_5(id_funct7_5), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_alu_res_src(id_alu_res_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_5(ex_funct7_5), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_alu_res_src(ex_alu_res_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .stall_id(stall_id),
    .bubble_cnt(bubble_cnt)
  );

  // ctl: {alu_src, alu_res_src, mem_read, mem_write,
  //       branch, mem_to_reg, reg_write}
  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] pc, a, b, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    logic            f75;
    logic [1:0]      op;
    logic [6:0]      ctl;
  } ex_t;

  localparam logic [6:0] C_LW  = 7'b1010011;
  localparam logic [6:0] C_ADD = 7'b0000001;
  localparam logic [6:0] C_SW  = 7'b1001000;

  ex_t m = '0;
  int unsigned nb = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctl_out();
    return {ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write,
            ex_branch, ex_mem_to_reg, ex_reg_write};
  endfunction

  function automatic logic m_hazard();
    logic r1, r2;
    r1 = id_uses_rs1 && id_rs1 == m.rd;
    r2 = id_uses_rs2 && id_rs2 == m.rd;
    return m.v && m.ctl[4] && m.rd != 0 && id_valid && (r1 || r2);
  endfunction

  task automatic ins(input logic v, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2,
                     input logic [6:0] ctl, input logic [1:0] op,
                     input logic [31:0] pc);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    {id_alu_src, id_alu_res_src, id_mem_read, id_mem_write,
     id_branch, id_mem_to_reg, id_reg_write} = ctl;
    id_alu_op = op; id_pc = pc;
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7_5 = 1'($urandom);
  endtask

  task automatic tick();
    ex_t n;
    logic hz;
    int unsigned sat;
    #1;
    hz = m_hazard();
    chk("stall_id", stall_id, (hz | ex_hold) & ~flush);
    n = m;
    if (rst) begin
      n = '0;
      nb = 0;
    end else if (flush) begin
      n.v = 0; n.op = 0; n.ctl = 0;
    end else if (ex_hold) begin
      n = m;
    end else if (hz) begin
      n.v = 0; n.op = 0; n.ctl = 0;
      nb++;
    end else begin
      n.v = id_valid; n.pc = id_pc; n.a = id_rs1_data;
      n.b = id_rs2_data; n.imm = id_imm; n.rs1 = id_rs1;
      n.rs2 = id_rs2; n.rd = id_rd; n.f3 = id_funct3;
      n.f75 = id_funct7_5;
      n.op = id_valid ? id_alu_op : 2'b00;
      n.ctl = id_valid ? {id_alu_src, id_alu_res_src, id_mem_read,
                          id_mem_write, id_branch, id_mem_to_reg,
                          id_reg_write} : 7'd0;
    end
    @(posedge clk);
    #1;
    m = n;
    sat = (nb > CNT_MAX) ? CNT_MAX : nb;
    chk("ex_valid", ex_valid, m.v);
    chk("ex_alu_op", ex_alu_op, m.op);
    chk("ex_ctl", ctl_out(), m.ctl);
    chk("bubble_cnt", bubble_cnt, sat);
    if (m.v) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_ops", {ex_rs1_data, ex_rs2_data}, {m.a, m.b});
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_idx", {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5},
          {m.rs1, m.rs2, m.rd, m.f3, m.f75});
    end
  endtask

  initial begin
    rst = 1; flush = 0; ex_hold = 0;
    ins(1, 5'h1f, 5'h1f, 5'h1f, 1, 1, 7'h7f, 2'b11, '1);
    id_rs1_data = '1; id_rs2_data = '1; id_imm = '1;
    id_funct3 = '1; id_funct7_5 = 1;
    @(posedge clk);
    #1;
    tick();
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_idx", {ex_rs1, ex_rs2, ex_rd}, 0);
    rst = 0;

    ins(1, 7, 1, 2, 1, 1, C_ADD, 2'b10, 32'h100);
    tick();
    chk("pt_pc", ex_pc, 32'h100);
    chk("pt_op", ex_alu_op, 2'b10);

    ins(1, 5, 1, 0, 1, 0, C_LW, 2'b00, 32'h104);
    tick();
    ins(1, 6, 5, 1, 1, 1, C_ADD, 2'b10, 32'h108);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", bubble_cnt, 1);
    tick();
    chk("lu_add_rd", ex_rd, 6);
    chk("lu_add_pc", ex_pc, 32'h108);

    ins(1, 0, 1, 0, 1, 0, C_LW, 2'b00, 32'h10c);
    tick();
    ins(1, 6, 0, 0, 1, 1, C_ADD, 2'b10, 32'h110);
    tick();
    chk("x0_nostall", ex_valid, 1);

    ins(1, 5, 1, 0, 1, 0, C_LW, 2'b00, 32'h114);
    tick();
    ins(1, 9, 3, 5, 1, 0, C_ADD, 2'b00, 32'h118);
    tick();
    chk("unused_rs2", bubble_cnt, 1);

    ins(1, 5, 1, 0, 1, 0, C_LW, 2'b00, 32'h11c);
    tick();
    ins(1, 0, 2, 5, 1, 1, C_SW, 2'b00, 32'h120);
    tick();
    chk("sw_stall_cnt", bubble_cnt, 2);
    tick();

    ins(1, 5, 1, 0, 1, 0, C_LW, 2'b00, 32'h124);
    tick();
    ins(1, 0, 2, 5, 1, 1, C_SW, 2'b00, 32'h128);
    flush = 1;
    tick();
    flush = 0;
    chk("fl_memw", ex_mem_write, 0);
    chk("fl_cnt", bubble_cnt, 2);

    ins(1, 11, 4, 4, 1, 1, C_ADD, 2'b01, 32'h200);
    tick();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      ins(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          1, 1, 7'($urandom), 2'($urandom), $urandom);
      tick();
      chk("hold_pc", ex_pc, 32'h200);
    end
    flush = 1;
    tick();
    chk("hold_flush", ex_valid, 0);
    flush = 0; ex_hold = 0;

    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      ins(1, 5, 1, 0, 1, 0, C_LW, 2'b00, 32'h300);
      tick();
      ins(1, 6, 5, 5, 1, 1, C_ADD, 2'b10, 32'h304);
      tick();
    end
    chk("sat_cnt", bubble_cnt, CNT_MAX);

    ins(1, 5, 1, 0, 1, 0, C_LW, 2'b00, 32'h400);
    tick();
    ins(1, 6, 5, 5, 1, 1, C_ADD, 2'b10, 32'h404);
    rst = 1;
    tick();
    rst = 0;
    chk("midstall_rst", bubble_cnt, 0);

    for (int i = 0; i < 3000; i++) begin
      ins(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom), 1'($urandom), 7'($urandom), 2'($urandom),
          $urandom);
      flush = ($urandom_range(0, 15) == 0);
      ex_hold = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 127) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
